// File: rtl/xpb_pkg.sv
// xpb_pkg: shared widths, table depth and FSM state type
// for the xpb table generator and its arithmetic helpers.
package xpb_pkg;

  localparam int XPB_WIDTH    = 1024;
  localparam int XPB_SEL_BITS = 5;
  localparam int XPB_ENTRIES  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FINAL
  } xpb_state_e;

endpackage

// File: rtl/xpb_table_gen_if.sv
// xpb_table_gen_if: control, operand, table-write and result
// signals of the xpb table generator; master=loader, slave=generator.
interface xpb_table_gen_if #(
  parameter int WIDTH    = 1024,
  parameter int SEL_BITS = 5
);

  logic                start;
  logic [WIDTH-1:0]    base;
  logic [WIDTH-1:0]    modulus;
  logic                busy;
  logic                done;
  logic                wr_en;
  logic [SEL_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic [WIDTH-1:0]    next_base;
  logic                error;

  modport master (
    output start, base, modulus,
    input  busy, done, wr_en, wr_addr,
    input  wr_data, next_base, error
  );

  modport slave (
    input  start, base, modulus,
    output busy, done, wr_en, wr_addr,
    output wr_data, next_base, error
  );

endinterface

// File: rtl/xpb_mod_add.sv
// xpb_mod_add: combinational (a+b) mod n for a,b < n.
// Ports: a_i, b_i, n_i in WIDTH; sum_o out WIDTH.
module xpb_mod_add #(
  parameter int WIDTH = 1024
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH-1:0] sum_o
);

  logic [WIDTH:0] s;
  logic [WIDTH:0] d;
  logic [WIDTH:0] n_ext;

  // carry bit kept so a+b never wraps before the compare
  assign n_ext = {1'b0, n_i};
  assign s     = {1'b0, a_i} + {1'b0, b_i};
  assign d     = s - n_ext;
  assign sum_o = (s >= n_ext) ? d[WIDTH-1:0]
                              : s[WIDTH-1:0];

endmodule

// File: rtl/xpb_table_gen.sv
// xpb_table_gen: streams k*base mod N for k=0..2^SEL_BITS-1 and
// yields next_base; ports clk, reset, bus (slave); XPB_GEN_CHECK_EN.
module xpb_table_gen
  import xpb_pkg::*;
#(
  parameter int WIDTH    = XPB_WIDTH,
  parameter int SEL_BITS = XPB_SEL_BITS
) (
  input  logic         clk,
  input  logic         reset,
  xpb_table_gen_if.slave bus
);

  localparam int IW = SEL_BITS + 1;
  localparam logic [IW-1:0] LAST =
    IW'((1 << SEL_BITS) - 1);

  xpb_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] sum;
  logic             bad;

  xpb_mod_add #(.WIDTH(WIDTH)) u_add (
    .a_i   (acc_q),
    .b_i   (base_q),
    .n_i   (mod_q),
    .sum_o (sum)
  );

`ifdef XPB_GEN_CHECK_EN
  assign bad = (bus.base >= bus.modulus);
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    base_d  = base_q;
    mod_d   = mod_q;
    nb_d    = nb_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          base_d  = bus.base;
          mod_d   = bus.modulus;
          acc_d   = '0;
          idx_d   = '0;
          err_d   = bad;
          // rejected operands skip straight to the done cycle
          state_d = bad ? ST_FINAL : ST_FILL;
        end
      end
      ST_FILL: begin
        acc_d = sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          // capture now so next_base is valid with done
          nb_d    = sum;
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      mod_q   <= '0;
      nb_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      mod_q   <= mod_d;
      nb_q    <= nb_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_FINAL);
  assign bus.wr_en     = (state_q == ST_FILL);
  assign bus.wr_addr   = idx_q[SEL_BITS-1:0];
  assign bus.wr_data   = acc_q;
  assign bus.next_base = nb_q;
  assign bus.error     = err_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// tb_xpb_table_gen: random and directed table builds checked
// against k*base mod N computed directly; WIDTH=16, SEL_BITS=5.
module tb_xpb_table_gen;

  localparam int W = 16;
  localparam int S = 5;
  localparam int E = 1 << S;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] last_nb = '0;

  xpb_table_gen_if #(.WIDTH(W), .SEL_BITS(S)) bus ();

  xpb_table_gen #(.WIDTH(W), .SEL_BITS(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [63:0] obs,
                       logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_entry(
    longint unsigned k, longint unsigned b,
    longint unsigned n);
    return W'((k * b) % n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full build; start sampled at the first edge
  task automatic run_build(logic [W-1:0] b,
                           logic [W-1:0] n);
    int  nwr;
    bit  got;
    nwr = 0;
    got = 1'b0;
    bus.start   = 1'b1;
    bus.base    = b;
    bus.modulus = n;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (c == 1) check("busy_c1", bus.busy, 1);
      if (bus.wr_en) begin
        check("wr_addr", bus.wr_addr, c - 1);
        check("wr_data", bus.wr_data,
              ref_entry(c - 1, b, n));
        nwr++;
      end
      if (bus.done) begin
        got = 1'b1;
        last_nb = ref_entry(E, b, n);
        check("done_cyc", c, E + 1);
        check("next_base", bus.next_base, last_nb);
        check("busy_done", bus.busy, 1);
        check("error_ok", bus.error, 0);
      end
      // a stray start mid-build must not restart
      bus.start = (c == 5);
      bus.base  = (c == 5) ? ~b : b;
      if (!got) tick();
    end
    bus.start = 1'b0;
    bus.base  = b;
    check("nwrites", nwr, E);
    if (!got) check("done_seen", 0, 1);
    tick();
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);
  endtask

  initial begin
    logic [W-1:0] n;
    logic [W-1:0] b;
    bit           hit;
    bus.start   = 1'b0;
    bus.base    = '0;
    bus.modulus = '0;
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_addr", bus.wr_addr, 0);
    check("rst_data", bus.wr_data, 0);
    check("rst_nb", bus.next_base, 0);
    check("rst_err", bus.error, 0);
    reset = 1'b0;
    tick();

    run_build(16'h1234, 16'hFFF1);
    check("nb_1234", last_nb, 16'h469E);
    // chained: feed previous result straight back
    run_build(last_nb, 16'hFFF1);
    run_build(16'hFFF0, 16'hFFF1);
    check("nb_fff0", last_nb, 16'hFFD1);
    run_build(16'h0000, 16'hFFF1);
    run_build(16'h0000, 16'h0001);

    repeat (6) begin
      n = W'($urandom_range(1, 16'hFFFF));
      b = W'($urandom_range(0, int'(n) - 1));
      run_build(b, n);
    end

    // reset while addr 10 is being written
    bus.start   = 1'b1;
    bus.base    = 16'h0777;
    bus.modulus = 16'hFFF1;
    tick();
    bus.start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (bus.wr_en && bus.wr_addr == 10) hit = 1'b1;
      else tick();
    end
    check("addr10_seen", hit, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_wr_en", bus.wr_en, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_nb", bus.next_base, 0);
    check("mrst_done", bus.done, 0);
    for (int c = 0; c < 35; c++) begin
      if (bus.done) check("mrst_nodone", 1, 0);
      tick();
    end
    run_build(16'h0777, 16'hFFF1);

`ifdef XPB_GEN_CHECK_EN
    bus.start   = 1'b1;
    bus.base    = 16'hFFF1;
    bus.modulus = 16'hFFF1;
    tick();
    bus.start = 1'b0;
    check("err_done", bus.done, 1);
    check("err_flag", bus.error, 1);
    check("err_wr_en", bus.wr_en, 0);
    check("err_nb", bus.next_base, last_nb);
    tick();
    check("err_done_off", bus.done, 0);
    check("err_hold", bus.error, 1);
    check("err_wr_en2", bus.wr_en, 0);
    tick();
    check("err_hold2", bus.error, 1);
    run_build(16'h0001, 16'hFFF1);
`else
    check("err_tied", bus.error, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
